// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: RAW scoreboard, then rs1/rs2 reads over the single register-file port.
// Write-back always owns the port; operands are handed to execute over valid/ready.
module operand_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_use_rs1,
  input  logic                  in_use_rs2,
  input  logic                  in_writes_rd,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_index,
  input  logic [DATA_WIDTH-1:0] wb_value,
  output logic [ADDR_WIDTH-1:0] rf_index,
  output logic                  rf_read_enable,
  output logic                  rf_write_enable,
  output logic [DATA_WIDTH-1:0] rf_value_in,
  input  logic [DATA_WIDTH-1:0] rf_value_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_op1,
  output logic [DATA_WIDTH-1:0] out_op2,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_writes_rd,
  output logic [NUM_REGS-1:0]   busy_flags
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_RD1   = 3'd2;
  localparam logic [2:0] S_RD2   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                  need1_q, need1_d, need2_q, need2_d, wr_q, wr_d;
  logic                  pend1_q, pend1_d, pend2_q, pend2_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  hazard;
  logic                  handshake;

  // need flags already exclude register 0, which is never busy and reads as zero
  assign hazard    = (need1_q && busy_q[rs1_q]) || (need2_q && busy_q[rs2_q]);
  assign handshake = (state_q == S_OUT) && out_ready;

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    need1_d = need1_q;
    need2_d = need2_q;
    wr_d    = wr_q;
    pend1_d = pend1_q;
    pend2_d = pend2_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          rs1_d   = in_rs1;
          rs2_d   = in_rs2;
          rd_d    = in_rd;
          need1_d = in_use_rs1 && (in_rs1 != '0);
          need2_d = in_use_rs2 && (in_rs2 != '0);
          wr_d    = in_writes_rd;
          op1_d   = '0;
          op2_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!hazard) begin
          if (need1_q)      state_d = S_RD1;
          else if (need2_q) state_d = S_RD2;
          else              state_d = S_OUT;
        end
      end
      S_RD1: begin
        if (!wb_valid) begin
          pend1_d = 1'b1;
          state_d = need2_q ? S_RD2 : S_FIN;
        end
      end
      S_RD2: begin
        // rs1 data is captured on the first RD2 cycle even if write-back holds the port
        if (pend1_q) begin
          op1_d   = rf_value_out;
          pend1_d = 1'b0;
        end
        if (!wb_valid) begin
          pend2_d = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (pend1_q) op1_d = rf_value_out;
        if (pend2_q) op2_d = rf_value_out;
        pend1_d = 1'b0;
        pend2_d = 1'b0;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Set after clear so an issuing writer wins over a same-cycle write-back
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_index] = 1'b0;
    if (handshake && wr_q && (rd_q != '0)) busy_d[rd_q] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    rf_index        = '0;
    rf_read_enable  = 1'b0;
    rf_write_enable = 1'b0;
    rf_value_in     = '0;
    if (wb_valid) begin
      rf_index        = wb_index;
      rf_value_in     = wb_value;
      rf_write_enable = (wb_index != '0);
    end else if (state_q == S_RD1) begin
      rf_index       = rs1_q;
      rf_read_enable = 1'b1;
    end else if (state_q == S_RD2) begin
      rf_index       = rs2_q;
      rf_read_enable = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      need1_q <= 1'b0;
      need2_q <= 1'b0;
      wr_q    <= 1'b0;
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      need1_q <= need1_d;
      need2_q <= need2_d;
      wr_q    <= wr_d;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_OUT);
  assign out_op1       = op1_q;
  assign out_op2       = op2_q;
  assign out_rd        = rd_q;
  assign out_writes_rd = wr_q;
  assign busy_flags    = busy_q;

endmodule
